// File: rtl/morse_key_timer_if.sv
// Symbol channel of morse_key_timer: a one-entry valid/ready output register.
interface morse_key_timer_if;
    logic       sym_valid;
    logic       sym_ready;
    logic [1:0] sym_code;

    modport master (output sym_valid, output sym_code, input sym_ready);
    modport slave  (input sym_valid, input sym_code, output sym_ready);
endinterface

// File: rtl/morse_key_timer.sv
// Morse key timer: synchronise and debounce key_in, time presses/gaps in ticks, emit symbols.
// Optional stuck-key detection is enabled by defining MORSE_STUCK_DET_EN.
module morse_key_timer #(
    parameter int unsigned CNT_W            = 24,
    parameter int unsigned DEBOUNCE_TICKS   = 100000,
    parameter int unsigned DOT_MAX_TICKS    = 2000000,
    parameter int unsigned LETTER_GAP_TICKS = 3000000,
    parameter int unsigned WORD_GAP_TICKS   = 7000000
`ifdef MORSE_STUCK_DET_EN
    ,
    parameter int unsigned STUCK_TICKS      = 16000000
`endif
) (
    input  logic              clk_100Mhz,
    input  logic              reset_n,
    input  logic              tick_10Mhz,
    input  logic              key_in,
    morse_key_timer_if.master sym,
    output logic              key_db,
    output logic              overflow,
    output logic              stuck_err
);

    typedef enum logic [1:0] {S_IDLE, S_PRESS, S_SPACE} state_t;
    typedef enum logic [1:0] {
        SYM_DOT    = 2'b00,
        SYM_DASH   = 2'b01,
        SYM_LETTER = 2'b10,
        SYM_WORD   = 2'b11
    } sym_t;

    localparam logic [CNT_W-1:0] L_DEBOUNCE = CNT_W'(DEBOUNCE_TICKS);
    localparam logic [CNT_W-1:0] L_DOT_MAX  = CNT_W'(DOT_MAX_TICKS);
    localparam logic [CNT_W-1:0] L_LETTER   = CNT_W'(LETTER_GAP_TICKS);
    localparam logic [CNT_W-1:0] L_WORD     = CNT_W'(WORD_GAP_TICKS);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_key_db;
    logic             r_db_d;
    logic             r_tick_d;
    logic [CNT_W-1:0] r_db_cnt;
    logic [CNT_W-1:0] w_db_inc;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_dur;
    logic             r_valid;
    sym_t             r_code;
    logic             r_ovf;
    logic             w_emit;
    sym_t             w_code;
    logic             w_rise;
    logic             w_fall;

    assign w_db_inc = r_db_cnt + 1'b1;
    assign w_rise   = r_key_db & ~r_db_d;
    assign w_fall   = ~r_key_db & r_db_d;

    always_ff @(posedge clk_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_key_db <= 1'b0;
            r_db_d   <= 1'b0;
            r_tick_d <= 1'b0;
            r_db_cnt <= '0;
        end else begin
            r_sync1  <= key_in;
            r_sync2  <= r_sync1;
            r_db_d   <= r_key_db;
            r_tick_d <= tick_10Mhz;
            if (r_sync2 == r_key_db) begin
                r_db_cnt <= '0;
            end else if (tick_10Mhz) begin
                if (w_db_inc == L_DEBOUNCE) begin
                    r_key_db <= ~r_key_db;
                    r_db_cnt <= '0;
                end else begin
                    r_db_cnt <= w_db_inc;
                end
            end
        end
    end

`ifdef MORSE_STUCK_DET_EN
    localparam logic [CNT_W-1:0] L_STUCK = CNT_W'(STUCK_TICKS);
    logic r_stuck;
`endif

    always_comb begin
        w_emit = 1'b0;
        w_code = SYM_DOT;
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_rise) w_next = S_PRESS;
            end
            S_PRESS: begin
                if (w_fall) begin
                    w_emit = 1'b1;
                    w_code = (r_dur < L_DOT_MAX) ? SYM_DOT : SYM_DASH;
                    w_next = S_SPACE;
`ifdef MORSE_STUCK_DET_EN
                    if (r_stuck) begin
                        w_emit = 1'b0;
                        w_next = S_IDLE;
                    end
`endif
                end
            end
            S_SPACE: begin
                // r_tick_d marks the cycle right after the count stepped, so each threshold fires once
                if (r_tick_d && r_dur == L_WORD) begin
                    w_emit = 1'b1;
                    w_code = SYM_WORD;
                    w_next = S_IDLE;
                end else if (r_tick_d && r_dur == L_LETTER) begin
                    w_emit = 1'b1;
                    w_code = SYM_LETTER;
                end
                if (w_rise) w_next = S_PRESS;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_100Mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_dur   <= '0;
            r_valid <= 1'b0;
            r_code  <= SYM_DOT;
            r_ovf   <= 1'b0;
`ifdef MORSE_STUCK_DET_EN
            r_stuck <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_dur <= '0;
            end else if (tick_10Mhz && r_state != S_IDLE && r_dur != '1) begin
                r_dur <= r_dur + 1'b1;
            end

            if (w_emit) begin
                if (!r_valid || sym.sym_ready) begin
                    r_valid <= 1'b1;
                    r_code  <= w_code;
                end else begin
                    r_ovf <= 1'b1;
                end
            end else if (sym.sym_ready) begin
                r_valid <= 1'b0;
            end
`ifdef MORSE_STUCK_DET_EN
            if (w_fall) begin
                r_stuck <= 1'b0;
            end else if (r_state == S_PRESS && r_dur >= L_STUCK) begin
                r_stuck <= 1'b1;
            end
`endif
        end
    end

    assign key_db        = r_key_db;
    assign overflow      = r_ovf;
    assign sym.sym_valid = r_valid;
    assign sym.sym_code  = r_code;
`ifdef MORSE_STUCK_DET_EN
    assign stuck_err     = r_stuck;
`else
    assign stuck_err     = 1'b0;
`endif

endmodule

// File: doc/morse_key_timer.md
Name: morse_key_timer

Overview:
- Downstream consumer of the 10 MHz tick pulse from the clock divider. Runs in the 100 MHz domain.
- Synchronises and debounces the raw Morse key input.
- Measures key-down and key-up durations in tick units and classifies them as DOT, DASH, LETTER_GAP or WORD_GAP.
- Delivers each symbol to the downstream character decoder through a one-entry valid/ready output register.

Parameters:
- CNT_W, 24: width of the debounce and duration counters, in ticks.
- DEBOUNCE_TICKS, 100000: stable ticks required to accept a key change (10 ms).
- DOT_MAX_TICKS, 2000000: a press shorter than this is a DOT, otherwise a DASH (200 ms).
- LETTER_GAP_TICKS, 3000000: key-up ticks that emit LETTER_GAP.
- WORD_GAP_TICKS, 7000000: key-up ticks that emit WORD_GAP.
- STUCK_TICKS, 16000000: key-down ticks that flag a stuck key (optional feature only).
- Legal configuration: 0 < DOT_MAX_TICKS < LETTER_GAP_TICKS < WORD_GAP_TICKS ≤ 2^CNT_W−1.

Ports:
- clk_100Mhz, input, 1: system clock.
- reset_n, input, 1: asynchronous, active-low reset.
- tick_10Mhz, input, 1: one-cycle enable pulse from the divider.
- key_in, input, 1: raw asynchronous key, 1 = pressed.
- sym_ready, input, 1: downstream accepts the symbol.
- sym_valid, output, 1: symbol pending.
- sym_code, output, 2: 00 DOT, 01 DASH, 10 LETTER_GAP, 11 WORD_GAP.
- key_db, output, 1: debounced key level, for LED echo.
- overflow, output, 1: sticky flag, a symbol was dropped.
- stuck_err, output, 1: stuck-key flag.

Behaviour:
- Reset: reset_n low forces every output to 0, the FSM to IDLE, and all counters and sync flops to 0, immediately (asynchronous). Reset in mid-operation discards any in-progress measurement and any pending symbol.
- Synchroniser: a 2-flop synchroniser on key_in, clocked every clk_100Mhz cycle, produces key_s.
- Debounce counter:
  - Advances only on cycles where tick_10Mhz = 1.
  - Clears on any cycle where key_s == key_db.
  - On a tick where key_s != key_db and the count reaches DEBOUNCE_TICKS, key_db toggles and the counter clears.
- Duration counter:
  - Increments only on tick cycles and saturates at 2^CNT_W−1.
  - Clears on every state transition.
- FSM states: IDLE, PRESS, SPACE.
  - IDLE: key_db rise → PRESS. The count is not running.
  - PRESS: key_db fall → emit DOT if count < DOT_MAX_TICKS, else DASH; go to SPACE.
  - SPACE, key_db rise → PRESS. No gap symbol is emitted for an intra-character space.
  - SPACE, count becomes exactly LETTER_GAP_TICKS → emit LETTER_GAP and stay in SPACE.
  - SPACE, count becomes exactly WORD_GAP_TICKS → emit WORD_GAP and go to IDLE.
  - SPACE, key_db rise on the same cycle a gap threshold is reached → the gap symbol is emitted and the FSM goes to PRESS.
- Emission latency: sym_valid and sym_code are registered one clk_100Mhz cycle after the classifying event.
- Output register handshake:
  - A symbol transfers when sym_valid && sym_ready.
  - sym_code is held stable while sym_valid && !sym_ready.
  - A new symbol arriving while the register is full and not being accepted is dropped, and overflow is set until reset.
  - Accept and a new symbol on the same cycle: the new symbol loads, sym_valid stays 1, and there is no overflow.
- Count arithmetic: DOT/DASH classification compares the press length in whole ticks counted while in PRESS, unsigned at CNT_W bits.

Optional Feature:
- Macro: MORSE_STUCK_DET_EN.
- Defined:
  - A PRESS count reaching STUCK_TICKS sets stuck_err.
  - stuck_err clears on the next key_db fall.
  - That release emits nothing; the FSM goes to IDLE, not SPACE.
- Undefined:
  - stuck_err is tied to 0.
  - No stuck logic is synthesised.
  - Long presses classify as DASH.

Test Plan:
Bench overrides: DEBOUNCE_TICKS=4, DOT_MAX_TICKS=20, LETTER_GAP_TICKS=30, WORD_GAP_TICKS=70, STUCK_TICKS=100; tick_10Mhz pulses every 10 cycles; sym_ready=1 unless stated.
- Reset: drop reset_n mid-PRESS with key held → all outputs 0 at once; after release, with key held, key_db rises again after 4 ticks and no stale symbol appears.
- Bounce: key_in high for 3 ticks then low, repeated 5 times → key_db stays 0, no sym_valid.
- Press 10 ticks → DOT (00). Press 19 ticks → DOT. Press 20 ticks → DASH (01). Each symbol appears 1 cycle after the key_db fall.
- Gap sequence:
  - Dot, release 15 ticks, dot → two DOTs, no gap symbol.
  - Then release 80 ticks → LETTER_GAP (10) at key-up tick 30 and WORD_GAP (11) at tick 70; FSM in IDLE, no further symbols.
- Backpressure: sym_ready=0 across DOT then DASH → DOT held stable, overflow=1, DASH lost. Raise sym_ready → one transfer, sym_valid falls, overflow stays 1.
- MORSE_STUCK_DET_EN: hold 120 ticks → stuck_err=1 at tick 100, no symbol on release, stuck_err=0 after key_db falls. Without the macro: the same stimulus gives DASH and stuck_err=0.
